// File: rtl/types.sv
// Shared RV32I decode types: instruction formats, opcodes and the decoded payload
// carried through the decode stage registers.
package types;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    INVALID_TYPE
  } inst_format_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0]  pc;
    inst_format_e fmt;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm;
    logic         illegal;
  } decoded_inst_t;

  function automatic decoded_inst_t decoded_reset();
    decoded_inst_t d;
    d         = '0;
    d.fmt     = INVALID_TYPE;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if;
  import types::*;

  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  inst_i;
  logic [31:0]  pc_i;
  logic         flush_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  pc_o;
  inst_format_e format_o;
  logic [6:0]   opcode_o;
  logic [2:0]   funct3_o;
  logic [6:0]   funct7_o;
  logic [4:0]   rs1_o;
  logic [4:0]   rs2_o;
  logic [4:0]   rd_o;
  logic [31:0]  imm_o;
  logic         illegal_o;

  modport slave (
    input  in_valid_i, inst_i, pc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, format_o, opcode_o, funct3_o, funct7_o,
           rs1_o, rs2_o, rd_o, imm_o, illegal_o
  );

  modport master (
    output in_valid_i, inst_i, pc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, format_o, opcode_o, funct3_o, funct7_o,
           rs1_o, rs2_o, rd_o, imm_o, illegal_o
  );

endinterface

// File: rtl/inst_decode_comb.sv
// Purely combinational RV32I field/format/immediate decode with illegal check.
module inst_decode_comb import types::*; #(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic [31:0]   inst_i,
  input  logic [31:0]   pc_i,
  output decoded_inst_t dec_o
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7_raw;
  inst_format_e fmt;
  logic [31:0]  imm;
  logic         illegal;
  logic         shift_imm;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7_raw = inst_i[31:25];
  assign shift_imm  = (opcode == OPC_OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);

  always_comb begin
    fmt = INVALID_TYPE;
    case (opcode)
      OPC_OP:                          fmt = R_TYPE;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:  fmt = I_TYPE;
      OPC_MISC_MEM, OPC_SYSTEM:        fmt = ENABLE_SYSTEM ? I_TYPE : INVALID_TYPE;
      OPC_STORE:                       fmt = S_TYPE;
      OPC_BRANCH:                      fmt = B_TYPE;
      OPC_LUI, OPC_AUIPC:              fmt = U_TYPE;
      OPC_JAL:                         fmt = J_TYPE;
      default:                         fmt = INVALID_TYPE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      I_TYPE:  imm = {{20{inst_i[31]}}, inst_i[31:20]};
      S_TYPE:  imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      B_TYPE:  imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      U_TYPE:  imm = {inst_i[31:12], 12'b0};
      J_TYPE:  imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                      1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    illegal = (inst_i[1:0] != 2'b11) || (fmt == INVALID_TYPE);
    case (opcode)
      OPC_OP: begin
        if (!((funct7_raw == 7'b0000000) ||
              (funct7_raw == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
              (funct7_raw == 7'b0000001 && ENABLE_M))) begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 && funct7_raw != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7_raw != 7'b0000000 && funct7_raw != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD:   if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      OPC_STORE:  if (funct3 > 3'b010) illegal = 1'b1;
      OPC_BRANCH: if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      OPC_JALR:   if (funct3 != 3'b000) illegal = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.fmt     = fmt;
    dec_o.opcode  = opcode;
    dec_o.funct3  = funct3;
    dec_o.funct7  = (fmt == R_TYPE || shift_imm) ? funct7_raw : 7'b0;
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    dec_o.rd      = inst_i[11:7];
    dec_o.imm     = imm;
    dec_o.illegal = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus skid register, so in_ready depends
// only on local state while keeping full throughput and strict FIFO order.
module decode_stage import types::*; #(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input logic          clk_i,
  input logic          rst_i,
  decode_stage_if.slave bus
);

  decoded_inst_t dec;
  decoded_inst_t or_q, or_d;
  decoded_inst_t sr_q, sr_d;
  logic          or_valid_q, or_valid_d;
  logic          sr_valid_q, sr_valid_d;
  logic          accept;
  logic          drain;

  inst_decode_comb #(
    .ENABLE_M      (ENABLE_M),
    .ENABLE_SYSTEM (ENABLE_SYSTEM)
  ) u_decode (
    .inst_i (bus.inst_i),
    .pc_i   (bus.pc_i),
    .dec_o  (dec)
  );

  assign accept = bus.in_valid_i && !sr_valid_q && !bus.flush_i;
  assign drain  = or_valid_q && bus.out_ready_i;

  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    if (bus.flush_i) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (drain) begin
      if (sr_valid_q) begin
        // Skid entry refills the output; a same-cycle accept lands behind it.
        or_d       = sr_q;
        sr_valid_d = accept;
        if (accept) sr_d = dec;
      end else begin
        or_valid_d = accept;
        if (accept) or_d = dec;
      end
    end else if (accept) begin
      if (!or_valid_q) begin
        or_d       = dec;
        or_valid_d = 1'b1;
      end else begin
        sr_d       = dec;
        sr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_q       <= decoded_reset();
      sr_q       <= decoded_reset();
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  assign bus.in_ready_o  = !sr_valid_q;
  assign bus.out_valid_o = or_valid_q;
  assign bus.pc_o        = or_q.pc;
  assign bus.format_o    = or_q.fmt;
  assign bus.opcode_o    = or_q.opcode;
  assign bus.funct3_o    = or_q.funct3;
  assign bus.funct7_o    = or_q.funct7;
  assign bus.rs1_o       = or_q.rs1;
  assign bus.rs2_o       = or_q.rs2;
  assign bus.rd_o        = or_q.rd;
  assign bus.imm_o       = or_q.imm;
  assign bus.illegal_o   = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush and reset.
module tb_decode_stage;
  import types::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  decode_stage_if b0 ();
  decode_stage_if b1 ();

  decode_stage #(
    .ENABLE_M      (1'b0),
    .ENABLE_SYSTEM (1'b1)
  ) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b0.slave)
  );

  decode_stage #(
    .ENABLE_M      (1'b1),
    .ENABLE_SYSTEM (1'b0)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] inst, input logic [31:0] pc);
    b0.in_valid_i = valid;
    b0.inst_i     = inst;
    b0.pc_i       = pc;
    b1.in_valid_i = valid;
    b1.inst_i     = inst;
    b1.pc_i       = pc;
  endtask

  task automatic set_ctl(input logic ready, input logic flush);
    b0.out_ready_i = ready;
    b0.flush_i     = flush;
    b1.out_ready_i = ready;
    b1.flush_i     = flush;
  endtask

  // Offer one instruction with out_ready high; outputs are checked after the accept edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    drive(1'b1, inst, pc);
    step();
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(b0.out_valid_o), 32'd0);
    chk({tag, "_ready"}, 32'(b0.in_ready_o), 32'd1);
    chk({tag, "_fmt"}, 32'(b0.format_o), 32'(INVALID_TYPE));
    chk({tag, "_illegal"}, 32'(b0.illegal_o), 32'd0);
    chk({tag, "_pc"}, b0.pc_o, 32'h0);
    chk({tag, "_imm"}, b0.imm_o, 32'h0);
    chk({tag, "_rd"}, 32'(b0.rd_o), 32'd0);
    chk({tag, "_opcode"}, 32'(b0.opcode_o), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    set_ctl(1'b1, 1'b0);
    step();
    step();
    check_reset("rst");
    rst = 1'b0;

    // addi x1,x0,5
    send(32'h0050_0093, 32'h0000_0100);
    chk("addi_valid", 32'(b0.out_valid_o), 32'd1);
    chk("addi_fmt", 32'(b0.format_o), 32'(I_TYPE));
    chk("addi_rd", 32'(b0.rd_o), 32'd1);
    chk("addi_rs1", 32'(b0.rs1_o), 32'd0);
    chk("addi_imm", b0.imm_o, 32'd5);
    chk("addi_funct7", 32'(b0.funct7_o), 32'd0);
    chk("addi_illegal", 32'(b0.illegal_o), 32'd0);
    chk("addi_pc", b0.pc_o, 32'h0000_0100);
    chk("addi_opcode", 32'(b0.opcode_o), 32'h13);
    step();
    chk("addi_drained", 32'(b0.out_valid_o), 32'd0);

    // sub x3,x1,x2
    send(32'h4020_81B3, 32'h0000_0104);
    chk("sub_fmt", 32'(b0.format_o), 32'(R_TYPE));
    chk("sub_funct7", 32'(b0.funct7_o), 32'h20);
    chk("sub_rd", 32'(b0.rd_o), 32'd3);
    chk("sub_rs1", 32'(b0.rs1_o), 32'd1);
    chk("sub_rs2", 32'(b0.rs2_o), 32'd2);
    chk("sub_illegal", 32'(b0.illegal_o), 32'd0);

    // mul x3,x1,x2: rejected without M, accepted with M
    send(32'h0220_81B3, 32'h0000_0108);
    chk("mul_illegal_nom", 32'(b0.illegal_o), 32'd1);
    chk("mul_illegal_m", 32'(b1.illegal_o), 32'd0);
    chk("mul_fmt_m", 32'(b1.format_o), 32'(R_TYPE));
    chk("mul_funct7_m", 32'(b1.funct7_o), 32'h01);

    // fence: I-type with SYSTEM enabled, invalid without
    send(32'h0000_000F, 32'h0000_010C);
    chk("fence_fmt_sys", 32'(b0.format_o), 32'(I_TYPE));
    chk("fence_illegal_sys", 32'(b0.illegal_o), 32'd0);
    chk("fence_fmt_nosys", 32'(b1.format_o), 32'(INVALID_TYPE));
    chk("fence_illegal_nosys", 32'(b1.illegal_o), 32'd1);

    // beq x0,x0,-4
    send(32'hFE00_0EE3, 32'h0000_0110);
    chk("beq_fmt", 32'(b0.format_o), 32'(B_TYPE));
    chk("beq_imm", b0.imm_o, 32'hFFFF_FFFC);
    chk("beq_illegal", 32'(b0.illegal_o), 32'd0);

    // unknown opcode 0x7F
    send(32'h0000_007F, 32'h0000_0114);
    chk("inv_fmt", 32'(b0.format_o), 32'(INVALID_TYPE));
    chk("inv_imm", b0.imm_o, 32'h0);
    chk("inv_illegal", 32'(b0.illegal_o), 32'd1);

    // load with funct3=011 is illegal in RV32I
    send(32'h0000_3003, 32'h0000_0118);
    chk("ld_fmt", 32'(b0.format_o), 32'(I_TYPE));
    chk("ld_illegal", 32'(b0.illegal_o), 32'd1);

    // lui x1,0x12345
    send(32'h1234_50B7, 32'h0000_011C);
    chk("lui_fmt", 32'(b0.format_o), 32'(U_TYPE));
    chk("lui_imm", b0.imm_o, 32'h1234_5000);
    chk("lui_rd", 32'(b0.rd_o), 32'd1);
    step();
    chk("idle_valid", 32'(b0.out_valid_o), 32'd0);

    // Backpressure: three offered, two accepted
    set_ctl(1'b0, 1'b0);
    drive(1'b1, 32'h0010_0093, 32'h0000_0200);
    step();
    chk("bp1_valid", 32'(b0.out_valid_o), 32'd1);
    chk("bp1_ready", 32'(b0.in_ready_o), 32'd1);
    drive(1'b1, 32'h0020_0113, 32'h0000_0204);
    step();
    chk("bp2_ready", 32'(b0.in_ready_o), 32'd0);
    chk("bp2_pc", b0.pc_o, 32'h0000_0200);
    drive(1'b1, 32'h0030_0193, 32'h0000_0208);
    step();
    chk("bp3_ready", 32'(b0.in_ready_o), 32'd0);
    chk("bp3_hold_pc", b0.pc_o, 32'h0000_0200);
    chk("bp3_hold_imm", b0.imm_o, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    set_ctl(1'b1, 1'b0);
    step();
    chk("bp_drain1_valid", 32'(b0.out_valid_o), 32'd1);
    chk("bp_drain1_pc", b0.pc_o, 32'h0000_0204);
    chk("bp_drain1_rd", 32'(b0.rd_o), 32'd2);
    chk("bp_drain1_ready", 32'(b0.in_ready_o), 32'd1);
    step();
    chk("bp_drain2_valid", 32'(b0.out_valid_o), 32'd0);

    // Flush with both entries full and a new offer
    set_ctl(1'b0, 1'b0);
    drive(1'b1, 32'h0010_0093, 32'h0000_0300);
    step();
    drive(1'b1, 32'h0020_0113, 32'h0000_0304);
    step();
    drive(1'b1, 32'h0030_0193, 32'h0000_0308);
    set_ctl(1'b0, 1'b1);
    step();
    chk("flush_valid", 32'(b0.out_valid_o), 32'd0);
    chk("flush_ready", 32'(b0.in_ready_o), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    set_ctl(1'b1, 1'b0);
    step();
    chk("flush_after_valid", 32'(b0.out_valid_o), 32'd0);
    send(32'h0040_0213, 32'h0000_030C);
    chk("post_flush_valid", 32'(b0.out_valid_o), 32'd1);
    chk("post_flush_pc", b0.pc_o, 32'h0000_030C);
    chk("post_flush_rd", 32'(b0.rd_o), 32'd4);
    step();

    // Reset mid-stream with both entries full and an offer during reset
    set_ctl(1'b0, 1'b0);
    drive(1'b1, 32'h0050_0293, 32'h0000_0400);
    step();
    drive(1'b1, 32'h0060_0313, 32'h0000_0404);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h0070_0393, 32'h0000_0408);
    set_ctl(1'b1, 1'b0);
    step();
    check_reset("midrst");
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("midrst_after_valid", 32'(b0.out_valid_o), 32'd0);
    step();
    chk("midrst_after2_valid", 32'(b0.out_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
